// File: rtl/csr_seq_ctrl_pkg.sv
// Shared constants and types for the machine-CSR sequencer: CSR addresses,
// mstatus field positions, Zicsr op encoding and the sequencer state enum.
package csr_seq_ctrl_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    typedef enum logic [1:0] {
        CSR_OP_RW  = 2'b00,
        CSR_OP_RS  = 2'b01,
        CSR_OP_RC  = 2'b10,
        CSR_OP_RSV = 2'b11
    } csr_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_T_EPC,
        ST_T_CAUSE,
        ST_T_STAT,
        ST_T_VEC,
        ST_M_STAT,
        ST_M_EPC,
        ST_C_EXEC
    } state_e;

    function automatic logic is_mapped(input logic [11:0] addr);
        return addr inside {CSR_MSTATUS, CSR_MTVEC, CSR_MEPC, CSR_MCAUSE};
    endfunction

endpackage

// File: rtl/csr_seq_ctrl.sv
// Machine-CSR sequencer: arbitrates trap entry, mret and Zicsr requests and
// drives the CSR file's single port through fixed multi-cycle sequences.
module csr_seq_ctrl
    import csr_seq_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  trap_valid,
    output logic                  trap_ready,
    input  logic [DATA_WIDTH-1:0] trap_epc,
    input  logic [DATA_WIDTH-1:0] trap_cause,
    input  logic                  mret_valid,
    output logic                  mret_ready,
    input  logic                  csr_valid,
    output logic                  csr_ready,
    input  logic [1:0]            csr_op,
    input  logic [ADDR_WIDTH-1:0] csr_req_addr,
    input  logic [DATA_WIDTH-1:0] csr_src,
    input  logic                  csr_src_zero,
    output logic [ADDR_WIDTH-1:0] csr_addr,
    output logic [DATA_WIDTH-1:0] csr_wdata,
    output logic                  csr_wen,
    input  logic [DATA_WIDTH-1:0] csr_rdata,
    output logic                  redirect_valid,
    output logic [DATA_WIDTH-1:0] redirect_pc,
    output logic                  csr_done,
    output logic [DATA_WIDTH-1:0] csr_rd_data,
    output logic                  csr_illegal
);

    state_e                state, state_nxt;
    logic [DATA_WIDTH-1:0] pl_epc, pl_cause, pl_src;
    logic [ADDR_WIDTH-1:0] pl_addr;
    csr_op_e               pl_op;
    logic                  pl_src_zero;
    logic                  idle, trap_acc, mret_acc, csr_acc, csr_bad;
    logic [DATA_WIDTH-1:0] mstat;

    assign idle       = (state == ST_IDLE);
    assign trap_ready = idle;
    assign mret_ready = idle & ~trap_valid;
    assign csr_ready  = idle & ~trap_valid & ~mret_valid;
    assign trap_acc   = trap_valid & trap_ready;
    assign mret_acc   = mret_valid & mret_ready;
    assign csr_acc    = csr_valid & csr_ready;
    assign csr_bad    = (pl_op == CSR_OP_RSV) || !is_mapped(12'(pl_addr));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // NOTE: the payload is only consumed after an accept has loaded it, so it
    // carries no reset; its pre-accept contents are never observed.
    always_ff @(posedge clk) begin
        if (trap_acc) begin
            pl_epc   <= trap_epc;
            pl_cause <= trap_cause;
        end
        if (csr_acc) begin
            pl_op       <= csr_op_e'(csr_op);
            pl_addr     <= csr_req_addr;
            pl_src      <= csr_src;
            pl_src_zero <= csr_src_zero;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        csr_addr  = '0;
        csr_wdata = '0;
        csr_wen   = 1'b0;
        mstat     = csr_rdata;
        unique case (state)
            ST_IDLE: begin
                if (trap_acc)      state_nxt = ST_T_EPC;
                else if (mret_acc) state_nxt = ST_M_STAT;
                else if (csr_acc)  state_nxt = ST_C_EXEC;
            end
            ST_T_EPC: begin
                csr_addr  = ADDR_WIDTH'(CSR_MEPC);
                csr_wdata = pl_epc & ~DATA_WIDTH'(3);
                csr_wen   = 1'b1;
                state_nxt = ST_T_CAUSE;
            end
            ST_T_CAUSE: begin
                csr_addr  = ADDR_WIDTH'(CSR_MCAUSE);
                csr_wdata = pl_cause;
                csr_wen   = 1'b1;
                state_nxt = ST_T_STAT;
            end
            ST_T_STAT: begin
                mstat[MSTATUS_MPIE]                  = csr_rdata[MSTATUS_MIE];
                mstat[MSTATUS_MIE]                   = 1'b0;
                mstat[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
                csr_addr  = ADDR_WIDTH'(CSR_MSTATUS);
                csr_wdata = mstat;
                csr_wen   = 1'b1;
                state_nxt = ST_T_VEC;
            end
            ST_T_VEC: begin
                csr_addr  = ADDR_WIDTH'(CSR_MTVEC);
                state_nxt = ST_IDLE;
            end
            ST_M_STAT: begin
                mstat[MSTATUS_MIE]                   = csr_rdata[MSTATUS_MPIE];
                mstat[MSTATUS_MPIE]                  = 1'b1;
                mstat[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
                csr_addr  = ADDR_WIDTH'(CSR_MSTATUS);
                csr_wdata = mstat;
                csr_wen   = 1'b1;
                state_nxt = ST_M_EPC;
            end
            ST_M_EPC: begin
                csr_addr  = ADDR_WIDTH'(CSR_MEPC);
                state_nxt = ST_IDLE;
            end
            ST_C_EXEC: begin
                // Read of the old value and write-back share this one cycle.
                csr_addr = pl_addr;
                if (!csr_bad) begin
                    case (pl_op)
                        CSR_OP_RW: csr_wdata = pl_src;
                        CSR_OP_RS: csr_wdata = csr_rdata | pl_src;
                        CSR_OP_RC: csr_wdata = csr_rdata & ~pl_src;
                        default:   csr_wdata = '0;
                    endcase
                    csr_wen = !((pl_op != CSR_OP_RW) && pl_src_zero);
                end
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            csr_done       <= 1'b0;
            csr_rd_data    <= '0;
            csr_illegal    <= 1'b0;
        end else begin
            redirect_valid <= (state == ST_T_VEC) || (state == ST_M_EPC);
            csr_done       <= (state == ST_C_EXEC);
            csr_illegal    <= (state == ST_C_EXEC) && csr_bad;
            if (state == ST_T_VEC)      redirect_pc <= csr_rdata & ~DATA_WIDTH'(3);
            else if (state == ST_M_EPC) redirect_pc <= csr_rdata;
            if (state == ST_C_EXEC)     csr_rd_data <= csr_bad ? '0 : csr_rdata;
        end
    end

endmodule

// File: tb/tb_csr_seq_ctrl.sv
// Bench for csr_seq_ctrl: models the external CSR file, checks directed
// vectors and corner sequences, then random traffic against a reference model.
module tb_csr_seq_ctrl;
    import csr_seq_ctrl_pkg::*;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        trap_valid = 1'b0, mret_valid = 1'b0, csr_valid = 1'b0;
    logic        trap_ready, mret_ready, csr_ready;
    logic [31:0] trap_epc = '0, trap_cause = '0, csr_src = '0;
    logic [1:0]  csr_op = '0;
    logic [11:0] csr_req_addr = '0;
    logic        csr_src_zero = 1'b0;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata, csr_rdata, redirect_pc, csr_rd_data;
    logic        csr_wen, redirect_valid, csr_done, csr_illegal;

    always #5 clk = ~clk;

    csr_seq_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(12)) dut (
        .clk(clk), .rst_n(rst_n),
        .trap_valid(trap_valid), .trap_ready(trap_ready),
        .trap_epc(trap_epc), .trap_cause(trap_cause),
        .mret_valid(mret_valid), .mret_ready(mret_ready),
        .csr_valid(csr_valid), .csr_ready(csr_ready),
        .csr_op(csr_op), .csr_req_addr(csr_req_addr),
        .csr_src(csr_src), .csr_src_zero(csr_src_zero),
        .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_wen(csr_wen),
        .csr_rdata(csr_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .csr_done(csr_done), .csr_rd_data(csr_rd_data), .csr_illegal(csr_illegal)
    );

    // External CSR file, with a backdoor port for preloading.
    logic [31:0] f_mstatus = '0, f_mtvec = '0, f_mepc = '0, f_mcause = '0;
    logic        bk_we = 1'b0;
    logic [11:0] bk_addr = '0;
    logic [31:0] bk_data = '0;

    always_comb begin
        case (csr_addr)
            CSR_MSTATUS: csr_rdata = f_mstatus;
            CSR_MTVEC:   csr_rdata = f_mtvec;
            CSR_MEPC:    csr_rdata = f_mepc;
            CSR_MCAUSE:  csr_rdata = f_mcause;
            default:     csr_rdata = '0;
        endcase
    end

    always @(posedge clk) begin
        if (csr_wen) begin
            case (csr_addr)
                CSR_MSTATUS: f_mstatus <= csr_wdata;
                CSR_MTVEC:   f_mtvec   <= csr_wdata;
                CSR_MEPC:    f_mepc    <= csr_wdata;
                CSR_MCAUSE:  f_mcause  <= csr_wdata;
                default: ;
            endcase
        end
        if (bk_we) begin
            case (bk_addr)
                CSR_MSTATUS: f_mstatus <= bk_data;
                CSR_MTVEC:   f_mtvec   <= bk_data;
                CSR_MEPC:    f_mepc    <= bk_data;
                CSR_MCAUSE:  f_mcause  <= bk_data;
                default: ;
            endcase
        end
    end

    function automatic logic [31:0] file_rd(input logic [11:0] a);
        case (a)
            CSR_MSTATUS: return f_mstatus;
            CSR_MTVEC:   return f_mtvec;
            CSR_MEPC:    return f_mepc;
            CSR_MCAUSE:  return f_mcause;
            default:     return '0;
        endcase
    endfunction

    // Cycle counter and port/pulse monitor, sampled mid-cycle.
    typedef struct { int cyc; logic [11:0] addr; logic [31:0] data; } wr_t;
    typedef struct { int cyc; logic [31:0] val; logic done; logic ill; } pulse_t;

    int     cyc = 0;
    wr_t    wr_q[$], exp_wr[$];
    pulse_t red_q[$], done_q[$], exp_red[$], exp_done[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (csr_wen) wr_q.push_back('{cyc, csr_addr, csr_wdata});
        if (redirect_valid) red_q.push_back('{cyc, redirect_pc, 1'b0, 1'b0});
        if (csr_done || csr_illegal) done_q.push_back('{cyc, csr_rd_data, csr_done, csr_illegal});
    end

    // Reference model: architectural CSR contents plus the held output values.
    logic [31:0] ref_csr [logic [11:0]];
    logic [31:0] ref_pc = '0, ref_rd_data = '0;

    function automatic logic [31:0] ref_rd(input logic [11:0] a);
        return ref_csr.exists(a) ? ref_csr[a] : 32'h0;
    endfunction

    int n_vec = 0, n_miss = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_to(input int target);
        while (cyc < target) step();
    endtask

    task automatic clear_logs();
        wr_q.delete();
        red_q.delete();
        done_q.delete();
    endtask

    function automatic logic sel_ready(input int kind);
        return (kind == 0) ? trap_ready : (kind == 1) ? mret_ready : csr_ready;
    endfunction

    // Raise one request, wait (bounded) for its ready, return the accept
    // cycle N so that the first sequencing state is cycle N+1.
    task automatic accept(input int kind, output int n);
        int   budget = 0;
        logic rdy;
        case (kind)
            0:       trap_valid = 1'b1;
            1:       mret_valid = 1'b1;
            default: csr_valid  = 1'b1;
        endcase
        #1;
        rdy = sel_ready(kind);
        while (!rdy && budget < 50) begin
            step();
            budget++;
            rdy = sel_ready(kind);
        end
        check("accept_ready", 32'(rdy), 32'h1);
        @(posedge clk);
        #1;
        n = cyc - 1;
        trap_valid = 1'b0;
        mret_valid = 1'b0;
        csr_valid  = 1'b0;
        trap_epc = $urandom;
        trap_cause = $urandom;
        csr_op = 2'($urandom);
        csr_req_addr = 12'($urandom);
        csr_src = $urandom;
        csr_src_zero = 1'($urandom);
        clear_logs();
    endtask

    task automatic model_trap(input logic [31:0] epc, input logic [31:0] cause);
        logic [31:0] ms = ref_rd(CSR_MSTATUS);
        logic [31:0] ms_new = (ms & ~32'h0000_1888) | (ms[3] ? 32'h80 : 32'h0) | 32'h0000_1800;
        exp_wr.delete(); exp_red.delete(); exp_done.delete();
        exp_wr.push_back('{1, CSR_MEPC, epc & ~32'h3});
        exp_wr.push_back('{2, CSR_MCAUSE, cause});
        exp_wr.push_back('{3, CSR_MSTATUS, ms_new});
        ref_csr[CSR_MEPC]    = epc & ~32'h3;
        ref_csr[CSR_MCAUSE]  = cause;
        ref_csr[CSR_MSTATUS] = ms_new;
        ref_pc = ref_rd(CSR_MTVEC) & ~32'h3;
        exp_red.push_back('{5, ref_pc, 1'b0, 1'b0});
    endtask

    task automatic model_mret();
        logic [31:0] ms = ref_rd(CSR_MSTATUS);
        logic [31:0] ms_new = (ms & ~32'h0000_1888) | (ms[7] ? 32'h8 : 32'h0) | 32'h0000_1880;
        exp_wr.delete(); exp_red.delete(); exp_done.delete();
        exp_wr.push_back('{1, CSR_MSTATUS, ms_new});
        ref_csr[CSR_MSTATUS] = ms_new;
        ref_pc = ref_rd(CSR_MEPC);
        exp_red.push_back('{3, ref_pc, 1'b0, 1'b0});
    endtask

    task automatic set_csr_exp(input logic [11:0] a, input logic [31:0] rd, input logic wen,
                               input logic [31:0] nv, input logic ill);
        exp_wr.delete(); exp_red.delete(); exp_done.delete();
        if (wen) begin
            exp_wr.push_back('{1, a, nv});
            ref_csr[a] = nv;
        end
        exp_done.push_back('{2, rd, 1'b1, ill});
        ref_rd_data = rd;
    endtask

    task automatic model_csr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] src,
                             input logic zero);
        logic [31:0] old = ref_rd(a);
        logic        ill = !ref_csr.exists(a) || (op == 2'b11);
        logic [31:0] nv  = (op == 2'b00) ? src : (op == 2'b01) ? (old | src) : (old & ~src);
        set_csr_exp(a, ill ? 32'h0 : old, !ill && !(op != 2'b00 && zero), nv, ill);
    endtask

    task automatic verify(input int n, input int last, input string tag);
        wait_to(n + last);
        check({tag, "_wr_cnt"}, wr_q.size(), exp_wr.size());
        foreach (exp_wr[i]) if (i < wr_q.size()) begin
            check({tag, "_wr_cyc"}, wr_q[i].cyc, n + exp_wr[i].cyc);
            check({tag, "_wr_addr"}, 32'(wr_q[i].addr), 32'(exp_wr[i].addr));
            check({tag, "_wr_data"}, wr_q[i].data, exp_wr[i].data);
        end
        check({tag, "_red_cnt"}, red_q.size(), exp_red.size());
        foreach (exp_red[i]) if (i < red_q.size()) begin
            check({tag, "_red_cyc"}, red_q[i].cyc, n + exp_red[i].cyc);
            check({tag, "_red_pc"}, red_q[i].val, exp_red[i].val);
        end
        check({tag, "_done_cnt"}, done_q.size(), exp_done.size());
        foreach (exp_done[i]) if (i < done_q.size()) begin
            check({tag, "_done_cyc"}, done_q[i].cyc, n + exp_done[i].cyc);
            check({tag, "_done_flag"}, 32'(done_q[i].done), 32'h1);
            check({tag, "_rd_data"}, done_q[i].val, exp_done[i].val);
            check({tag, "_illegal"}, 32'(done_q[i].ill), 32'(exp_done[i].ill));
        end
        check({tag, "_pc_hold"}, redirect_pc, ref_pc);
        check({tag, "_rd_hold"}, csr_rd_data, ref_rd_data);
        check({tag, "_port_idle"}, 32'(csr_wen) | 32'(csr_addr) | csr_wdata, 32'h0);
    endtask

    task automatic run_trap(input logic [31:0] epc, input logic [31:0] cause, input string tag);
        int n;
        model_trap(epc, cause);
        trap_epc = epc;
        trap_cause = cause;
        accept(0, n);
        verify(n, 5, tag);
    endtask

    task automatic run_mret(input string tag);
        int n;
        model_mret();
        accept(1, n);
        verify(n, 3, tag);
    endtask

    task automatic drive_csr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] src,
                             input logic zero, input string tag);
        int n;
        csr_op = op;
        csr_req_addr = a;
        csr_src = src;
        csr_src_zero = zero;
        accept(2, n);
        verify(n, 2, tag);
    endtask

    task automatic preload(input logic [11:0] a, input logic [31:0] v);
        bk_addr = a;
        bk_data = v;
        bk_we = 1'b1;
        @(posedge clk);
        #1;
        bk_we = 1'b0;
        ref_csr[a] = v;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_redirect_valid"}, 32'(redirect_valid), 32'h0);
        check({tag, "_csr_done"}, 32'(csr_done), 32'h0);
        check({tag, "_csr_illegal"}, 32'(csr_illegal), 32'h0);
        check({tag, "_redirect_pc"}, redirect_pc, 32'h0);
        check({tag, "_csr_rd_data"}, csr_rd_data, 32'h0);
        check({tag, "_csr_port"}, 32'(csr_wen) | 32'(csr_addr) | csr_wdata, 32'h0);
        check({tag, "_readys"}, {29'h0, trap_ready, mret_ready, csr_ready}, 32'h7);
    endtask

    typedef struct {
        logic [1:0] op; logic [11:0] addr; logic [31:0] src; logic zero;
        logic [31:0] rd; logic wen; logic [31:0] nv; logic ill;
    } vec_t;

    vec_t vecs [8];
    logic [11:0] addr_pool [6];

    initial begin
        int n, m, c;
        logic [31:0] old_cause;

        // Directed vectors, valid after the trap + mret of the test plan.
        vecs[0] = '{2'b01, CSR_MTVEC,   32'h3,         1'b0, 32'h8000_0100, 1'b1, 32'h8000_0103, 1'b0};
        vecs[1] = '{2'b01, CSR_MTVEC,   32'h3,         1'b1, 32'h8000_0103, 1'b0, 32'h0,         1'b0};
        vecs[2] = '{2'b10, CSR_MTVEC,   32'h3,         1'b0, 32'h8000_0103, 1'b1, 32'h8000_0100, 1'b0};
        vecs[3] = '{2'b00, 12'h7C0,     32'h1234,      1'b0, 32'h0,         1'b0, 32'h0,         1'b1};
        vecs[4] = '{2'b00, CSR_MCAUSE,  32'hDEAD_BEEF, 1'b0, 32'h0000_000B, 1'b1, 32'hDEAD_BEEF, 1'b0};
        vecs[5] = '{2'b11, CSR_MSTATUS, 32'h0000_FFFF, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1};
        vecs[6] = '{2'b10, CSR_MSTATUS, 32'h8,         1'b1, 32'h0000_1888, 1'b0, 32'h0,         1'b0};
        vecs[7] = '{2'b00, CSR_MEPC,    32'h0,         1'b1, 32'h8000_0024, 1'b1, 32'h0,         1'b0};
        addr_pool = '{CSR_MSTATUS, CSR_MTVEC, CSR_MEPC, CSR_MCAUSE, 12'h7C0, 12'h000};
        ref_csr[CSR_MSTATUS] = '0;
        ref_csr[CSR_MTVEC]   = '0;
        ref_csr[CSR_MEPC]    = '0;
        ref_csr[CSR_MCAUSE]  = '0;

        repeat (2) step();
        check_reset_outputs("in_reset");
        rst_n = 1'b1;
        step();
        check_reset_outputs("after_reset");

        // Trap entry and mret from the test plan.
        preload(CSR_MSTATUS, 32'h0000_0008);
        preload(CSR_MTVEC,   32'h8000_0100);
        run_trap(32'h8000_0024, 32'd11, "trap");
        check("trap_mstatus", f_mstatus, 32'h0000_1880);
        check("trap_mcause", f_mcause, 32'h0000_000B);
        run_mret("mret");
        check("mret_mstatus", f_mstatus, 32'h0000_1888);
        check("mret_pc", redirect_pc, 32'h8000_0024);

        foreach (vecs[i]) begin
            set_csr_exp(vecs[i].addr, vecs[i].rd, vecs[i].wen, vecs[i].nv, vecs[i].ill);
            drive_csr(vecs[i].op, vecs[i].addr, vecs[i].src, vecs[i].zero, $sformatf("vec%0d", i));
        end
        check("vec_mtvec_final", f_mtvec, 32'h8000_0100);

        // All three requesters at once: trap, then mret at the trap redirect, then csr.
        step();
        trap_epc = 32'h0000_1002;
        trap_cause = 32'h8000_0007;
        csr_op = 2'b01;
        csr_req_addr = CSR_MTVEC;
        csr_src = 32'h0;
        csr_src_zero = 1'b1;
        trap_valid = 1'b1;
        mret_valid = 1'b1;
        csr_valid = 1'b1;
        #1;
        check("prio_readys", {29'h0, trap_ready, mret_ready, csr_ready}, 32'h4);
        model_trap(32'h0000_1002, 32'h8000_0007);
        @(posedge clk);
        #1;
        n = cyc - 1;
        trap_valid = 1'b0;
        clear_logs();
        for (int k = 1; k <= 5; k++) begin
            step();
            check("prio_mret_ready", 32'(mret_ready), 32'(k == 5));
            check("prio_csr_ready", 32'(csr_ready), 32'h0);
        end
        verify(n, 5, "prio_trap");
        model_mret();
        @(posedge clk);
        #1;
        m = cyc - 1;
        mret_valid = 1'b0;
        clear_logs();
        check("prio_mret_accept", m, n + 5);
        for (int k = 1; k <= 3; k++) begin
            step();
            check("prio_csr_ready_late", 32'(csr_ready), 32'(k == 3));
        end
        verify(m, 3, "prio_mret");
        model_csr(2'b01, CSR_MTVEC, 32'h0, 1'b1);
        @(posedge clk);
        #1;
        c = cyc - 1;
        csr_valid = 1'b0;
        clear_logs();
        check("prio_csr_accept", c, m + 3);
        verify(c, 2, "prio_csr");

        // Random traffic against the reference model.
        for (int i = 0; i < 40; i++) begin
            int unsigned kind = $urandom_range(0, 9);
            if (kind == 0) begin
                run_trap($urandom, $urandom, "rnd_trap");
            end else if (kind == 1) begin
                run_mret("rnd_mret");
            end else begin
                logic [1:0]  op   = 2'($urandom_range(0, 3));
                logic [11:0] a    = addr_pool[$urandom_range(0, 5)];
                logic [31:0] src  = $urandom;
                logic        zero = ($urandom_range(0, 3) == 0);
                model_csr(op, a, src, zero);
                drive_csr(op, a, src, zero, "rnd_csr");
            end
        end

        // Reset during T_CAUSE: mepc write survives, mcause and the redirect do not.
        old_cause = ref_rd(CSR_MCAUSE);
        trap_epc = 32'h4000_0013;
        trap_cause = 32'h0000_0005;
        accept(0, n);
        wait_to(n + 2);
        check("rst_in_tcause", (32'(csr_wen) << 12) | 32'(csr_addr), 32'h0000_1342);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        step();
        step();
        rst_n = 1'b1;
        ref_csr[CSR_MEPC] = 32'h4000_0010;
        ref_pc = '0;
        ref_rd_data = '0;
        repeat (8) step();
        check("rst_no_redirect", red_q.size(), 32'h0);
        check("rst_no_done", done_q.size(), 32'h0);
        check("rst_mepc_kept", f_mepc, 32'h4000_0010);
        check("rst_mcause_unchanged", f_mcause, old_cause);
        check_reset_outputs("post_reset");
        run_mret("rst_then_mret");

        foreach (addr_pool[i]) if (i < 4)
            check($sformatf("final_csr_%03h", addr_pool[i]), file_rd(addr_pool[i]), ref_rd(addr_pool[i]));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
